// File: rtl/q_sweep_sequencer.sv
// Q-setpoint sweep engine: steps q_desired through N_POINTS setpoints, waits for the Q loop
// to converge or time out at each one, pulses ctrl_rst between points and reports each point.
module q_sweep_sequencer #(
    parameter int          BUS_WIDTH   = 10,
    parameter int          N_POINTS    = 30,
    parameter int          STEP        = 5,
    parameter int          MODE        = 0,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          TIMEOUT_W   = 16,
    parameter int          MAX_TIMEOUT = 50000,
    parameter int          RST_CYCLES  = 5,
    localparam int         IDX_W       = (N_POINTS > 1) ? $clog2(N_POINTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic                 abort,
    input  logic                 converged,
    output logic [BUS_WIDTH-1:0] q_desired,
    output logic                 enable,
    output logic                 start,
    output logic                 ctrl_rst,
    output logic                 busy,
    output logic [IDX_W-1:0]     point_idx,
    output logic                 result_valid,
    output logic                 result_converged,
    output logic [TIMEOUT_W-1:0] result_cycles,
    output logic                 done
);

    localparam int MW = BUS_WIDTH + TIMEOUT_W;
    localparam int SW = MW + 16;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_RUN      = 3'd2;
    localparam logic [2:0] S_CTRL_RST = 3'd3;
    localparam logic [2:0] S_NEXT     = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    logic [2:0]           state_q, state_d;
    logic [BUS_WIDTH-1:0] q_desired_q, q_desired_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic                 res_valid_q, res_valid_d;
    logic                 res_conv_q, res_conv_d;
    logic [TIMEOUT_W-1:0] res_cycles_q, res_cycles_d;

    logic [MW-1:0]        idx_ext, lower, span, offset, setpoint;
    logic [SW-1:0]        scaled;
    logic [BUS_WIDTH-1:0] setpoint_sat;
    logic [15:0]          lfsr_next;
    logic                 last_point;

    // Setpoint for the current index; random mode scales the LFSR into [0, span].
    always_comb begin
        idx_ext  = MW'(idx_q);
        lower    = MW'(STEP) * (idx_ext + MW'(2));
        span     = MW'(STEP) * (idx_ext + MW'(1));
        scaled   = SW'(lfsr_q) * SW'(span + MW'(1));
        offset   = MW'(scaled >> 16);
        setpoint = (MODE == 1) ? lower + offset : lower;
        if (setpoint[MW-1:BUS_WIDTH] != '0) begin
            setpoint_sat = '1;
        end else begin
            setpoint_sat = setpoint[BUS_WIDTH-1:0];
        end
    end

    assign lfsr_next  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign last_point = (idx_q == IDX_W'(N_POINTS - 1));

    always_comb begin
        state_d      = state_q;
        q_desired_d  = q_desired_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        lfsr_d       = lfsr_q;
        res_valid_d  = 1'b0;
        res_conv_d   = res_conv_q;
        res_cycles_d = res_cycles_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (go) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                end
            end
            S_LOAD: begin
                q_desired_d = setpoint_sat;
                cnt_d       = '0;
                lfsr_d      = lfsr_next;
                state_d     = S_RUN;
            end
            S_RUN: begin
                // A flag already high on the first RUN cycle is left over from the previous point.
                if (converged && (cnt_q != '0)) begin
                    res_valid_d  = 1'b1;
                    res_conv_d   = 1'b1;
                    res_cycles_d = cnt_q;
                    cnt_d        = '0;
                    state_d      = S_CTRL_RST;
                end else if (cnt_q == TIMEOUT_W'(MAX_TIMEOUT - 1)) begin
                    res_valid_d  = 1'b1;
                    res_conv_d   = 1'b0;
                    res_cycles_d = TIMEOUT_W'(MAX_TIMEOUT);
                    cnt_d        = '0;
                    state_d      = S_CTRL_RST;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_W'(1);
                end
            end
            S_CTRL_RST: begin
                if (cnt_q == TIMEOUT_W'(RST_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_NEXT;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_W'(1);
                end
            end
            S_NEXT: begin
                if (last_point) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort drops the point in flight without reporting it and clears the visible outputs.
        if (abort && (state_q != S_IDLE)) begin
            state_d      = S_IDLE;
            q_desired_d  = '0;
            idx_d        = '0;
            cnt_d        = '0;
            lfsr_d       = lfsr_q;
            res_valid_d  = 1'b0;
            res_conv_d   = 1'b0;
            res_cycles_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            q_desired_q  <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            lfsr_q       <= LFSR_SEED;
            res_valid_q  <= 1'b0;
            res_conv_q   <= 1'b0;
            res_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            q_desired_q  <= q_desired_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            lfsr_q       <= lfsr_d;
            res_valid_q  <= res_valid_d;
            res_conv_q   <= res_conv_d;
            res_cycles_q <= res_cycles_d;
        end
    end

    assign q_desired        = q_desired_q;
    assign point_idx        = idx_q;
    assign enable           = (state_q == S_RUN) || (state_q == S_CTRL_RST);
    assign start            = enable;
    assign ctrl_rst         = (state_q == S_CTRL_RST);
    assign busy             = (state_q == S_LOAD) || (state_q == S_RUN) ||
                              (state_q == S_CTRL_RST) || (state_q == S_NEXT);
    assign done             = (state_q == S_DONE);
    assign result_valid     = res_valid_q;
    assign result_converged = res_conv_q;
    assign result_cycles    = res_cycles_q;

endmodule

// File: tb/tb_q_sweep_sequencer.sv
// Bench for q_sweep_sequencer: three parameterisations share one stimulus path selected by sel;
// expected setpoints and per-point results come from the arithmetic rules of the sweep.
module tb_q_sweep_sequencer;

    localparam int MAXT = 100;
    localparam int RSTC = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int   sel = 0;
    logic go = 1'b0, abort = 1'b0, conv = 1'b0;
    int   total = 0, bad = 0;
    int   q_seen [30];
    int   q_seq0 [30];

    // instance 0: ascending, 3 points; 1: narrow bus, saturating; 2: random mode, 30 points
    logic       go_a, ab_a, cv_a, go_b, ab_b, cv_b, go_c, ab_c, cv_c;
    logic [9:0] q_a, q_c;
    logic [5:0] q_b;
    logic [1:0] idx_a, idx_b;
    logic [4:0] idx_c;
    logic       en_a, st_a, cr_a, bz_a, rv_a, rc_a, dn_a;
    logic       en_b, st_b, cr_b, bz_b, rv_b, rc_b, dn_b;
    logic       en_c, st_c, cr_c, bz_c, rv_c, rc_c, dn_c;
    logic [15:0] cy_a, cy_b, cy_c;

    assign go_a = go & (sel == 0);  assign ab_a = abort & (sel == 0);  assign cv_a = conv & (sel == 0);
    assign go_b = go & (sel == 1);  assign ab_b = abort & (sel == 1);  assign cv_b = conv & (sel == 1);
    assign go_c = go & (sel == 2);  assign ab_c = abort & (sel == 2);  assign cv_c = conv & (sel == 2);

    q_sweep_sequencer #(.BUS_WIDTH(10), .N_POINTS(3), .STEP(5), .MODE(0),
                        .MAX_TIMEOUT(MAXT), .RST_CYCLES(RSTC)) u_a (
        .clk(clk), .rst(rst), .go(go_a), .abort(ab_a), .converged(cv_a),
        .q_desired(q_a), .enable(en_a), .start(st_a), .ctrl_rst(cr_a), .busy(bz_a),
        .point_idx(idx_a), .result_valid(rv_a), .result_converged(rc_a),
        .result_cycles(cy_a), .done(dn_a));

    q_sweep_sequencer #(.BUS_WIDTH(6), .N_POINTS(3), .STEP(20), .MODE(0),
                        .MAX_TIMEOUT(MAXT), .RST_CYCLES(RSTC)) u_b (
        .clk(clk), .rst(rst), .go(go_b), .abort(ab_b), .converged(cv_b),
        .q_desired(q_b), .enable(en_b), .start(st_b), .ctrl_rst(cr_b), .busy(bz_b),
        .point_idx(idx_b), .result_valid(rv_b), .result_converged(rc_b),
        .result_cycles(cy_b), .done(dn_b));

    q_sweep_sequencer #(.BUS_WIDTH(10), .N_POINTS(30), .STEP(5), .MODE(1),
                        .MAX_TIMEOUT(MAXT), .RST_CYCLES(RSTC)) u_c (
        .clk(clk), .rst(rst), .go(go_c), .abort(ab_c), .converged(cv_c),
        .q_desired(q_c), .enable(en_c), .start(st_c), .ctrl_rst(cr_c), .busy(bz_c),
        .point_idx(idx_c), .result_valid(rv_c), .result_converged(rc_c),
        .result_cycles(cy_c), .done(dn_c));

    logic [9:0]  cur_q;
    logic [4:0]  cur_idx;
    logic [15:0] cur_cy;
    logic        cur_en, cur_st, cur_cr, cur_bz, cur_rv, cur_rc, cur_dn;

    always_comb begin
        cur_q = q_a; cur_idx = {3'b0, idx_a}; cur_cy = cy_a;
        cur_en = en_a; cur_st = st_a; cur_cr = cr_a; cur_bz = bz_a;
        cur_rv = rv_a; cur_rc = rc_a; cur_dn = dn_a;
        if (sel == 1) begin
            cur_q = {4'b0, q_b}; cur_idx = {3'b0, idx_b}; cur_cy = cy_b;
            cur_en = en_b; cur_st = st_b; cur_cr = cr_b; cur_bz = bz_b;
            cur_rv = rv_b; cur_rc = rc_b; cur_dn = dn_b;
        end else if (sel == 2) begin
            cur_q = q_c; cur_idx = idx_c; cur_cy = cy_c;
            cur_en = en_c; cur_st = st_c; cur_cr = cr_c; cur_bz = bz_c;
            cur_rv = rv_c; cur_rc = rc_c; cur_dn = dn_c;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int npoints(input int s);
        return (s == 2) ? 30 : 3;
    endfunction

    // Allowed setpoint window for point i of the selected instance.
    task automatic q_window(input int s, input int i, output int lo, output int hi);
        if (s == 0) begin
            lo = 5 * (i + 2); hi = lo;
        end else if (s == 1) begin
            lo = 20 * (i + 2);
            if (lo > 63) lo = 63;
            hi = lo;
        end else begin
            lo = 5 * (i + 2); hi = 5 * (2 * i + 3);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "/busy"}, 32'(cur_bz), 0);
        chk({tag, "/done"}, 32'(cur_dn), 0);
        chk({tag, "/enable"}, 32'(cur_en), 0);
        chk({tag, "/start"}, 32'(cur_st), 0);
        chk({tag, "/ctrl_rst"}, 32'(cur_cr), 0);
        chk({tag, "/result_valid"}, 32'(cur_rv), 0);
        chk({tag, "/result_converged"}, 32'(cur_rc), 0);
        chk({tag, "/result_cycles"}, 32'(cur_cy), 0);
        chk({tag, "/q_desired"}, 32'(cur_q), 0);
        chk({tag, "/point_idx"}, 32'(cur_idx), 0);
    endtask

    task automatic start_sweep();
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
        chk("load/busy", 32'(cur_bz), 1);
        chk("load/done", 32'(cur_dn), 0);
        chk("load/point_idx", 32'(cur_idx), 0);
    endtask

    function automatic int rand_plan();
        int r;
        r = int'($urandom_range(0, 130));
        return (r > MAXT - 1) ? -1 : r;
    endfunction

    // plan: RUN cycle from which converged is held high, -1 for never.
    task automatic run_point(input int i, input int plan, input bit last);
        int lo, hi, ec, ecyc, c, rc;
        bit econv;
        q_window(sel, i, lo, hi);
        econv = (plan >= 0) && (plan <= MAXT - 1);
        ec    = econv ? ((plan < 1) ? 1 : plan) : MAXT - 1;
        ecyc  = econv ? ec : MAXT;
        conv  = (plan == 0);
        @(negedge clk);
        chk("run/q_range", 32'((int'(cur_q) >= lo) && (int'(cur_q) <= hi)), 1);
        chk("run/enable", 32'(cur_en), 1);
        chk("run/start", 32'(cur_st), 1);
        chk("run/point_idx", 32'(cur_idx), 32'(i));
        chk("run/ctrl_rst", 32'(cur_cr), 0);
        q_seen[i] = int'(cur_q);
        c = 0;
        while (c < MAXT + 5) begin
            conv = (plan >= 0) && (c >= plan);
            @(negedge clk);
            if (cur_rv) break;
            c++;
        end
        chk("exit_cycle", 32'(c), 32'(ec));
        chk("result_converged", 32'(cur_rc), 32'(econv));
        chk("result_cycles", 32'(cur_cy), 32'(ecyc));
        chk("ctrl_rst/enable", 32'(cur_en), 1);
        conv = 1'b0;
        rc = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!cur_cr) break;
            rc++;
        end
        chk("ctrl_rst_len", 32'(rc), RSTC);
        chk("next/result_valid", 32'(cur_rv), 0);
        chk("next/busy", 32'(cur_bz), 1);
        @(negedge clk);
        if (last) begin
            chk("done/done", 32'(cur_dn), 1);
            chk("done/busy", 32'(cur_bz), 0);
            chk("done/enable", 32'(cur_en), 0);
            chk("done/q_range", 32'((int'(cur_q) >= lo) && (int'(cur_q) <= hi)), 1);
        end
    endtask

    task automatic sweep_random();
        int n;
        n = npoints(sel);
        start_sweep();
        for (int i = 0; i < n; i++) run_point(i, rand_plan(), i == n - 1);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            check_idle("reset");
        end

        // ascending sweep, convergence on cycle 7 of every point
        sel = 0;
        start_sweep();
        run_point(0, 7, 0);
        run_point(1, 7, 0);
        run_point(2, 7, 1);

        // timeout, stale flag, and converged rising on the last allowed cycle
        start_sweep();
        run_point(0, -1, 0);
        run_point(1, 0, 0);
        run_point(2, MAXT - 1, 1);
        sweep_random();

        // saturating narrow bus
        sel = 1;
        sweep_random();

        // random mode stays in its window and repeats after reset
        sel = 2;
        do_reset();
        start_sweep();
        for (int i = 0; i < 30; i++) run_point(i, int'($urandom_range(0, 6)), i == 29);
        for (int i = 0; i < 30; i++) q_seq0[i] = q_seen[i];
        do_reset();
        start_sweep();
        for (int i = 0; i < 30; i++) run_point(i, int'($urandom_range(0, 6)), i == 29);
        for (int i = 0; i < 30; i++) chk("lfsr_repeat", 32'(q_seen[i]), 32'(q_seq0[i]));

        // abort in RUN of point 4
        do_reset();
        start_sweep();
        for (int i = 0; i < 4; i++) run_point(i, 2, 0);
        @(negedge clk);
        chk("abort/point_idx", 32'(cur_idx), 4);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_idle("abort");
        repeat (4) begin
            @(negedge clk);
            chk("abort/no_result", 32'(cur_rv), 0);
        end
        start_sweep();
        run_point(0, 3, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_idle("abort_load");

        // reset in the middle of CTRL_RST
        sel = 0;
        start_sweep();
        @(negedge clk);
        conv = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid/result_valid", 32'(cur_rv), 1);
        chk("rst_mid/result_cycles", 32'(cur_cy), 1);
        conv = 1'b0;
        @(negedge clk);
        chk("rst_mid/ctrl_rst", 32'(cur_cr), 1);
        rst = 1'b1;
        @(negedge clk);
        check_idle("rst_mid");
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_mid/no_result", 32'(cur_rv), 0);
        end
        sweep_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
